// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared states, legal prescale values and frame bit indices for the UART RX controller
package uart_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CHECK} rx_state_e;
  localparam int BIT_CNT_W = 4;
  localparam logic [5:0] PRESCALE_8 = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;
  localparam logic [BIT_CNT_W-1:0] START_IDX = 4'd0;
  localparam logic [BIT_CNT_W-1:0] DATA_FIRST = 4'd1;
  localparam logic [BIT_CNT_W-1:0] DATA_LAST = 4'd8;
  localparam logic [BIT_CNT_W-1:0] PAR_IDX = 4'd9;
endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// uart_rx_edge_bit_cnt: oversampling edge counter and frame bit index with wrap/strobe-point flags
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 mode,
  input  logic [5:0]           p,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic                 wrap,
  output logic                 strb_pt,
  output logic                 chk_pt
);
  logic [4:0] edge_cnt;
  logic [4:0] strb_at;
  assign strb_at = p[5:1] + 5'(mode);
  assign wrap = en && edge_cnt == 5'(p - 6'd1);
  assign strb_pt = edge_cnt == strb_at;
  assign chk_pt = edge_cnt == strb_at + 5'd1;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      edge_cnt <= '0;
      bit_cnt <= START_IDX;
    end else if (en) begin
      edge_cnt <= wrap ? 5'd0 : edge_cnt + 5'd1;
      bit_cnt <= wrap ? bit_cnt + 4'd1 : bit_cnt;
    end
  end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer driving sample strobes, checker enables and frame result flags
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  PAR_EN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  samp_mode,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic [BIT_CNT_W-1:0]  BIT_COUNT,
  output logic                  sample_one_bit,
  output logic                  sample_three_bit,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  Data_valid,
  output logic                  par_error,
  output logic                  stp_error,
  output logic                  busy
);
  rx_state_e state, state_nxt;
  logic [5:0] p_q, p_sel;
  logic par_en_q, mode_q, active, wrap, strb_pt, chk_pt, starting;
  assign p_sel = (prescale == PRESCALE_W'(PRESCALE_16)) ? PRESCALE_16 :
                 (prescale == PRESCALE_W'(PRESCALE_32)) ? PRESCALE_32 : PRESCALE_8;
  assign starting = state == IDLE && !rx_in;
  uart_rx_edge_bit_cnt u_cnt (
    .clk     (clk),
    .rst     (rst),
    .en      (active),
    .clr     (state == IDLE || state_nxt == IDLE),
    .mode    (mode_q),
    .p       (p_q),
    .bit_cnt (BIT_COUNT),
    .wrap    (wrap),
    .strb_pt (strb_pt),
    .chk_pt  (chk_pt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      p_q <= PRESCALE_8;
      par_en_q <= 1'b0;
      mode_q <= 1'b0;
      Data_valid <= 1'b0;
      par_error <= 1'b0;
      stp_error <= 1'b0;
    end else begin
      state <= state_nxt;
      p_q <= starting ? p_sel : p_q;
      par_en_q <= starting ? PAR_EN : par_en_q;
      mode_q <= starting ? samp_mode : mode_q;
      Data_valid <= state == CHECK && !(stp_err || (par_en_q && par_err));
      par_error <= state == CHECK && par_en_q && par_err;
      stp_error <= state == CHECK && stp_err;
    end
  end
  // glitch abort is tested before the wrap so it wins when both coincide
  always_comb begin
    state_nxt = state;
    active = state == START || state == DATA || state == PARITY || state == STOP;
    busy = state != IDLE;
    sample_one_bit = active && !mode_q && strb_pt;
    sample_three_bit = active && mode_q && strb_pt;
    strt_chk_en = state == START && chk_pt;
    stp_chk_en = state == CHECK;
    par_chk_en = state == CHECK && par_en_q;
    case (state)
      IDLE:    state_nxt = !rx_in ? START : IDLE;
      START:   state_nxt = (strt_chk_en && strt_glitch) ? IDLE : wrap ? DATA : START;
      DATA:    state_nxt = (wrap && BIT_COUNT == DATA_LAST) ? (par_en_q ? PARITY : STOP) : DATA;
      PARITY:  state_nxt = wrap ? STOP : PARITY;
      STOP:    state_nxt = strb_pt ? CHECK : STOP;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench; stimulus queues expected output events, a monitor matches them per cycle
module tb_uart_rx_ctrl;
  logic clk = 0, rst = 1, rx_in = 1, PAR_EN = 0, samp_mode = 0;
  logic strt_glitch = 0, par_err = 0, stp_err = 0;
  logic [5:0] prescale = 6'd8;
  logic [3:0] BIT_COUNT;
  logic sample_one_bit, sample_three_bit, strt_chk_en, par_chk_en, stp_chk_en;
  logic Data_valid, par_error, stp_error, busy;
  int cyc = 0, n_tests = 0, n_fail = 0;
  localparam logic [7:0] S1 = 8'h80, S3 = 8'h40, STRT = 8'h20, PAR = 8'h10;
  localparam logic [7:0] STP = 8'h08, DV = 8'h04, PE = 8'h02, SE = 8'h01;
  typedef struct {int cyc; logic [7:0] fl; bit cb; logic [3:0] bc;} ev_t;
  ev_t exp_q[$];

  uart_rx_ctrl #(.PRESCALE_W(6)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .PAR_EN(PAR_EN), .prescale(prescale),
    .samp_mode(samp_mode), .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .BIT_COUNT(BIT_COUNT), .sample_one_bit(sample_one_bit), .sample_three_bit(sample_three_bit),
    .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
    .Data_valid(Data_valid), .par_error(par_error), .stp_error(stp_error), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] flags();
    return {sample_one_bit, sample_three_bit, strt_chk_en, par_chk_en, stp_chk_en,
            Data_valid, par_error, stp_error};
  endfunction

  function automatic void push(int c, logic [7:0] f, bit cb, logic [3:0] b);
    exp_q.push_back('{c, f, cb, b});
  endfunction

  task automatic check(string name, int act, int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] f;
    ev_t e;
    f = flags();
    if (f != 8'h00) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event at cycle %0d: flags %02h bit_count %0d", cyc, f, BIT_COUNT);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.fl != f || (e.cb && e.bc != BIT_COUNT)) begin
          n_fail++;
          $display("FAIL event: got cycle %0d flags %02h bit_count %0d, expected cycle %0d flags %02h bit_count %0d",
                   cyc, f, BIT_COUNT, e.cyc, e.fl, e.bc);
        end
      end
    end
  end

  task automatic wait_until(int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [5:0] pre, input int p, input logic [5:0] pre_mid, input bit mode,
                       input bit pe, input logic [7:0] d, input bit perr, input bit serr, input int tail);
    int c0, nb, last;
    logic [10:0] bits;
    nb = pe ? 11 : 10;
    bits = pe ? {1'b1, ^d, d, 1'b0} : {2'b11, d, 1'b0};
    tick();
    prescale = pre; PAR_EN = pe; samp_mode = mode; par_err = perr; stp_err = serr;
    c0 = cyc + 1;
    for (int k = 0; k < nb; k++) begin
      push(c0 + k*p + p/2 + int'(mode), mode ? S3 : S1, 1, 4'(k));
      if (k == 0) push(c0 + p/2 + int'(mode) + 1, STRT, 1, 4'd0);
    end
    last = c0 + (nb-1)*p + p/2 + int'(mode);
    push(last + 1, STP | (pe ? PAR : 8'h00), 0, 4'd0);
    push(last + 2, ((serr || (pe && perr)) ? 8'h00 : DV) | ((pe && perr) ? PE : 8'h00) | (serr ? SE : 8'h00), 0, 4'd0);
    for (int k = 0; k < nb-1; k++) begin
      rx_in = bits[k];
      if (k == 1) prescale = pre_mid;
      repeat (p) tick();
    end
    rx_in = 1;
    repeat (tail) tick();
  endtask

  initial begin
    int c0;
    repeat (3) tick();
    rst = 0;
    @(negedge clk);
    check("reset_flags", int'(flags()), 0);
    check("reset_bit_count", int'(BIT_COUNT), 0);
    check("reset_busy", int'(busy), 0);

    frame(8, 8, 8, 0, 0, 8'hA5, 0, 0, 20);
    frame(16, 16, 16, 1, 1, 8'h3C, 1, 0, 20);

    tick();
    prescale = 8; samp_mode = 0; PAR_EN = 0; strt_glitch = 1; rx_in = 0;
    c0 = cyc + 1;
    push(c0 + 4, S1, 1, 4'd0);
    push(c0 + 5, STRT, 1, 4'd0);
    tick();
    tick();
    rx_in = 1;
    wait_until(c0 + 5);
    check("glitch_busy_before", int'(busy), 1);
    wait_until(c0 + 6);
    check("glitch_busy_after", int'(busy), 0);
    strt_glitch = 0;
    repeat (20) tick();

    frame(8, 8, 8, 0, 0, 8'h55, 0, 0, 9);
    frame(8, 8, 8, 0, 0, 8'hAA, 0, 0, 20);

    tick();
    prescale = 8; samp_mode = 0; PAR_EN = 0; rx_in = 0;
    c0 = cyc + 1;
    push(c0 + 4, S1, 1, 4'd0);
    push(c0 + 5, STRT, 1, 4'd0);
    for (int k = 1; k < 5; k++) push(c0 + 8*k + 4, S1, 1, 4'(k));
    repeat (8) tick();
    rx_in = 1;
    while (cyc < c0 + 40) tick();
    rst = 1;
    check("rst_mid_bit_count", int'(BIT_COUNT), 5);
    check("rst_mid_busy", int'(busy), 1);
    tick();
    rst = 0;
    check("rst_flags", int'(flags()), 0);
    check("rst_bit_count", int'(BIT_COUNT), 0);
    check("rst_busy", int'(busy), 0);
    repeat (5) tick();

    frame(8, 8, 8, 0, 0, 8'h0F, 0, 0, 20);
    frame(12, 8, 32, 0, 0, 8'hC3, 0, 0, 20);
    frame(32, 32, 32, 0, 1, 8'h81, 0, 1, 40);

    repeat (5) tick();
    check("pending_events", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
